// File: rtl/instr_encoder_pkg.sv
// Shared types and RV32I encoding constants for the instruction encoder.
// Holds the operation enum, opcode/funct3/funct7 values, the NOP word and the FIFO entry type.
package common;

  typedef enum logic [5:0] {
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } encode_op_type;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_type;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] NOP_WORD = 32'h00000013;

  typedef struct packed {
    logic [31:0] word;
    logic        error;
  } fifo_entry_t;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational RV32I field packing for one request.
// Defining INSTR_ENCODER_RANGE_CHECK_EN replaces unencodable immediates with a flagged NOP.
module instr_pack
  import common::*;
(
  input  logic          [4:0] rd,
  input  logic          [4:0] rs1,
  input  logic          [4:0] rs2,
  input  logic         [31:0] imm,
  input  encode_op_type       op,
  output logic         [31:0] word,
  output logic                error
);

  fmt_type     fmt;
  logic  [6:0] opcode;
  logic  [2:0] funct3;
  logic  [6:0] funct7;
  logic [31:0] raw;

  always_comb begin
    fmt    = FMT_R;
    opcode = OPC_OP;
    funct3 = F3_ADD;
    funct7 = F7_BASE;
    case (op)
      OP_LUI:   begin fmt = FMT_U; opcode = OPC_LUI;   end
      OP_AUIPC: begin fmt = FMT_U; opcode = OPC_AUIPC; end
      OP_JAL:   begin fmt = FMT_J; opcode = OPC_JAL;   end
      OP_JALR:  begin fmt = FMT_I; opcode = OPC_JALR;  funct3 = 3'b000; end
      OP_BEQ:   begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = F3_BEQ;  end
      OP_BNE:   begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = F3_BNE;  end
      OP_BLT:   begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = F3_BLT;  end
      OP_BGE:   begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = F3_BGE;  end
      OP_BLTU:  begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = F3_BLTU; end
      OP_BGEU:  begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = F3_BGEU; end
      OP_LB:    begin fmt = FMT_I; opcode = OPC_LOAD;  funct3 = F3_B;  end
      OP_LH:    begin fmt = FMT_I; opcode = OPC_LOAD;  funct3 = F3_H;  end
      OP_LW:    begin fmt = FMT_I; opcode = OPC_LOAD;  funct3 = F3_W;  end
      OP_LBU:   begin fmt = FMT_I; opcode = OPC_LOAD;  funct3 = F3_BU; end
      OP_LHU:   begin fmt = FMT_I; opcode = OPC_LOAD;  funct3 = F3_HU; end
      OP_SB:    begin fmt = FMT_S; opcode = OPC_STORE; funct3 = F3_B;  end
      OP_SH:    begin fmt = FMT_S; opcode = OPC_STORE; funct3 = F3_H;  end
      OP_SW:    begin fmt = FMT_S; opcode = OPC_STORE; funct3 = F3_W;  end
      OP_ADDI:  begin fmt = FMT_I; opcode = OPC_OP_IMM; funct3 = F3_ADD;  end
      OP_SLTI:  begin fmt = FMT_I; opcode = OPC_OP_IMM; funct3 = F3_SLT;  end
      OP_SLTIU: begin fmt = FMT_I; opcode = OPC_OP_IMM; funct3 = F3_SLTU; end
      OP_XORI:  begin fmt = FMT_I; opcode = OPC_OP_IMM; funct3 = F3_XOR;  end
      OP_ORI:   begin fmt = FMT_I; opcode = OPC_OP_IMM; funct3 = F3_OR;   end
      OP_ANDI:  begin fmt = FMT_I; opcode = OPC_OP_IMM; funct3 = F3_AND;  end
      OP_SLLI:  begin fmt = FMT_SH; opcode = OPC_OP_IMM; funct3 = F3_SLL; end
      OP_SRLI:  begin fmt = FMT_SH; opcode = OPC_OP_IMM; funct3 = F3_SR;  end
      OP_SRAI:  begin fmt = FMT_SH; opcode = OPC_OP_IMM; funct3 = F3_SR; funct7 = F7_ALT; end
      OP_ADD:   funct3 = F3_ADD;
      OP_SUB:   begin funct3 = F3_ADD; funct7 = F7_ALT; end
      OP_SLL:   funct3 = F3_SLL;
      OP_SLT:   funct3 = F3_SLT;
      OP_SLTU:  funct3 = F3_SLTU;
      OP_XOR:   funct3 = F3_XOR;
      OP_SRL:   funct3 = F3_SR;
      OP_SRA:   begin funct3 = F3_SR; funct7 = F7_ALT; end
      OP_OR:    funct3 = F3_OR;
      OP_AND:   funct3 = F3_AND;
      default:  ;
    endcase
  end

  // Register fields a format does not use are simply left out of its concatenation.
  always_comb begin
    raw = '0;
    case (fmt)
      FMT_R:   raw = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:   raw = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_SH:  raw = {funct7, imm[4:0], rs1, funct3, rd, opcode};
      FMT_S:   raw = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B:   raw = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:   raw = {imm[31:12], rd, opcode};
      FMT_J:   raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: raw = '0;
    endcase
  end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  logic signed [31:0] simm;
  logic               bad;

  assign simm = $signed(imm);

  always_comb begin
    bad = 1'b0;
    case (fmt)
      FMT_I, FMT_S: bad = (simm < -32'sd2048) || (simm > 32'sd2047);
      FMT_SH:       bad = (simm < 32'sd0) || (simm > 32'sd31);
      FMT_B:        bad = (simm < -32'sd4096) || (simm > 32'sd4094) || imm[0];
      FMT_J:        bad = (simm < -32'sd1048576) || (simm > 32'sd1048574) || imm[0];
      FMT_U:        bad = (imm[11:0] != 12'd0);
      default:      bad = 1'b0;
    endcase
  end

  assign word  = bad ? NOP_WORD : raw;
  assign error = bad;
`else
  assign word  = raw;
  assign error = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs requests into words behind a 2-entry FIFO and counts handoffs.
// Optional immediate range checking is enabled by defining INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder
  import common::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  encode_op_type          req_op,
  input  logic             [4:0] req_rd,
  input  logic             [4:0] req_rs1,
  input  logic             [4:0] req_rs2,
  input  logic            [31:0] req_imm,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic            [31:0] instr_word,
  output logic                   instr_error,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  logic [31:0] pack_word;
  logic        pack_error;

  instr_pack u_pack (
    .rd    (req_rd),
    .rs1   (req_rs1),
    .rs2   (req_rs2),
    .imm   (req_imm),
    .op    (req_op),
    .word  (pack_word),
    .error (pack_error)
  );

  fifo_entry_t            entry_q [2];
  fifo_entry_t            entry_d [2];
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic             [1:0] occ_q, occ_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   push, pop;

  assign req_ready   = (occ_q != 2'd2);
  assign instr_valid = (occ_q != 2'd0);
  assign push        = req_valid && req_ready;
  assign pop         = instr_valid && instr_ready;

  // Gating on instr_valid keeps the word and error at zero whenever nothing is buffered.
  assign instr_word  = instr_valid ? entry_q[rd_ptr_q].word  : 32'd0;
  assign instr_error = instr_valid ? entry_q[rd_ptr_q].error : 1'b0;
  assign instr_count = count_q;

  always_comb begin
    entry_d  = entry_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    count_d  = count_q;
    if (push) begin
      entry_d[wr_ptr_q] = '{word: pack_word, error: pack_error};
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      if (count_q != '1) count_d = count_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      count_q    <= '0;
    end else begin
      entry_q    <= entry_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      count_q    <= count_d;
    end
  end

endmodule
